mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative 32-bit signed multiplier/divider that serves the multicycle CPU's MULT and DIV instructions. The control unit pulses `start` with the operation selected; this block runs a fixed 32-iteration sequence, then returns a 64-bit result as `hi`/`lo` plus a one-cycle `done`. It raises `div0` when the divisor is zero, which feeds the control unit's exception path. HI/LO architectural registers stay outside this block; the control unit latches `hi`/`lo` into them with its `write` signal.

## Interface
- `WIDTH`, 32, operand width; iteration count equals `WIDTH`.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset_in` input 1: synchronous, active-high reset.
- `start` input 1: request pulse from the control unit; sampled only in IDLE.
- `op` input 1: 0 = MULT, 1 = DIV; sampled with `start`.
- `a` input 32: rs operand (multiplicand/dividend), from register A; sampled with `start`.
- `b` input 32: rt operand (multiplier/divisor), from register B; sampled with `start`.
- `busy` output 1: high whenever the state is not IDLE.
- `done` output 1: one-cycle pulse; `hi`/`lo`/`div0` are valid from this cycle.
- `hi` output 32: MULT high word / DIV remainder.
- `lo` output 32: MULT low word / DIV quotient.
- `div0` output 1: divide-by-zero flag; holds until the next accepted `start`.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: 32 iterations, counter 0..31.
  - FIX: sign correction and result load.
  - DONE: `done` = 1.
- IDLE with `start` = 1:
  - latch `op`, `a`, `b`; clear `div0`.
  - if `op` = DIV and `b` = 0: set `div0` = 1 and go to DONE; `hi`/`lo` keep their previous values.
  - otherwise go to RUN with the counter at 0.
- MULT in RUN:
  - radix-2 Booth over a 65-bit accumulator {P[63:0], q_-1}.
  - each cycle: add/subtract the multiplicand on P[63:32] per {P[0], q_-1}, then arithmetic-shift right by 1.
  - full signed 64-bit product; no overflow is possible.
- DIV in RUN:
  - restoring division on magnitudes |a| and |b|, one quotient bit per cycle, using a 33-bit partial remainder.
- After counter = 31, go to FIX.
- FIX:
  - MULT: `hi` = P[63:32], `lo` = P[31:0].
  - DIV: `lo` = quotient negated if a[31] XOR b[31]; `hi` = remainder negated if a[31] (sign of dividend, MIPS rule).
  - then go to DONE.
- DONE: go to IDLE unconditionally.
- Arithmetic rules:
  - `|x|` uses a 32-bit two's-complement negate, so |0x80000000| = 0x80000000 treated as unsigned 2^31.
  - 0x80000000 / 0xFFFFFFFF yields `lo` = 0x80000000, `hi` = 0, with no flag.
- `start` while `busy`, including the DONE cycle, is ignored; no queuing.
- `a`/`b`/`op` may change freely after the sampling edge.

## Timing
- Reset: `busy` = 0, `done` = 0, `div0` = 0, `hi` = 0, `lo` = 0, state IDLE, counter 0.
  - Reset takes priority over everything, including mid-RUN; no partial result is written.
- Normal latency: `start` sampled at edge E.
  - RUN during edges E+1..E+32.
  - FIX at edge E+33 writes `hi`/`lo`.
  - `done` is high for the one cycle following edge E+33, i.e. 34 edges after E.
  - back in IDLE after edge E+34; a new `start` can be accepted at edge E+35.
- Div-by-zero latency: `start` sampled at edge E gives `div0` = 1 and `done` = 1 in the cycle after E; IDLE after E+1.
- `busy` rises in the cycle after the sampling edge and falls with the end of the `done` cycle.
- `hi`/`lo` change only at the FIX edge or on reset; they are stable between operations.

## Structure
- Shared package `cpu_defs`:
  - MD_OP_MULT/MD_OP_DIV encodings.
  - mult_div state enum (IDLE, RUN, FIX, DONE).
  - MD_ITER = 32.
- No sub-module: both algorithms share one 33-bit add/sub and one shift register pair, with `op` selecting the datapath; a separate divider instance would duplicate the adder.

## Test plan
- MULT a=7, b=0xFFFFFFFD (-3) -> `done` 34 cycles after start; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `div0`=0.
- MULT a=b=0x80000000 -> `hi`=0x40000000, `lo`=0x00000000.
- DIV a=0xFFFFFFF9 (-7), b=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIV a=5, b=0 with prior `hi`=0x11, `lo`=0x22 -> `div0`=1 and `done`=1 one cycle after start; `hi`/`lo` unchanged; next MULT clears `div0`.
- `start` pulsed at cycles 5 and 20 of a running MULT, and during DONE -> ignored; exactly one `done`; result matches the first operands.
- `reset_in` asserted at RUN iteration 17 -> next cycle `busy`=0, `hi`=`lo`=0, `done` never pulses; a fresh MULT 3*4 gives `lo`=12, `hi`=0.

Source files
------------

// File: rtl/cpu_defs.sv
// ============================================================================
//  Module   : cpu_defs
//  Brief    : Shared CPU definitions: mult/div op encodings, FSM states, sizes
//  Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_defs;

    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV  = 1'b1;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

endpackage

`default_nettype wire

// File: rtl/mult_div_unit_if.sv
// ============================================================================
//  Module   : mult_div_unit_if
//  Brief    : Control-unit <-> multiplier/divider request/result bundle
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface mult_div_unit_if
    import cpu_defs::*;
#(
    parameter int WIDTH = MD_ITER
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div0;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div0
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div0
    );
endinterface

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
//  Module   : mult_div_unit
//  Brief    : Iterative signed Booth multiplier / restoring divider, shared adder
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mult_div_unit
    import cpu_defs::*;
#(
    parameter int WIDTH = MD_ITER
) (
    input  wire logic       clk,
    input  wire logic       reset_in,
    mult_div_unit_if.slave  md
);

    localparam int               CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    md_state_e          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_op;
    logic               r_a_neg;
    logic               r_q_neg;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH:0]   r_p;
    logic               r_busy;
    logic               r_done;
    logic               r_div0;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH:0]     w_x;
    logic [WIDTH:0]     w_y;
    logic               w_sub;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH:0]   w_p_next;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
    assign w_a_abs = md.a[WIDTH-1] ? (~md.a + WIDTH'(1)) : md.a;
    assign w_b_abs = md.b[WIDTH-1] ? (~md.b + WIDTH'(1)) : md.b;

    assign w_quot = r_p[WIDTH-1:0];
    assign w_rem  = r_p[2*WIDTH-1:WIDTH];

    // MULT: r_p = {P, q_-1}. DIV: r_p = {partial remainder, dividend/quotient}.
    always_comb begin
        w_x      = '0;
        w_y      = '0;
        w_sub    = 1'b0;
        w_p_next = r_p;
        if (r_op == MD_OP_MULT) begin
            w_x = {r_p[2*WIDTH], r_p[2*WIDTH:WIDTH+1]};
            unique case (r_p[1:0])
                2'b01:   w_y = {r_mcand[WIDTH-1], r_mcand};
                2'b10: begin
                    w_y   = {r_mcand[WIDTH-1], r_mcand};
                    w_sub = 1'b1;
                end
                default: w_y = '0;
            endcase
        end else begin
            w_x   = r_p[2*WIDTH-1:WIDTH-1];
            w_y   = {1'b0, r_mcand};
            w_sub = 1'b1;
        end

        w_sum = w_x + (w_sub ? ~w_y : w_y) + (WIDTH+1)'(w_sub);

        if (r_op == MD_OP_MULT) begin
            // 33-bit sum absorbs the add overflow, so the shift stays exact.
            w_p_next = {w_sum, r_p[WIDTH:1]};
        end else if (!w_sum[WIDTH]) begin
            w_p_next = {w_sum, r_p[WIDTH-2:0], 1'b1};
        end else begin
            w_p_next = {w_x, r_p[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_op    <= MD_OP_MULT;
            r_a_neg <= 1'b0;
            r_q_neg <= 1'b0;
            r_mcand <= '0;
            r_p     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_div0  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            unique case (r_state)
                MD_IDLE: begin
                    if (md.start) begin
                        r_op    <= md.op;
                        r_a_neg <= md.a[WIDTH-1];
                        r_q_neg <= md.a[WIDTH-1] ^ md.b[WIDTH-1];
                        r_div0  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        if (md.op == MD_OP_DIV && md.b == '0) begin
                            r_div0  <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= MD_DONE;
                        end else begin
                            r_state <= MD_RUN;
                            if (md.op == MD_OP_MULT) begin
                                r_mcand <= md.a;
                                r_p     <= {{WIDTH{1'b0}}, md.b, 1'b0};
                            end else begin
                                r_mcand <= w_b_abs;
                                r_p     <= {{(WIDTH+1){1'b0}}, w_a_abs};
                            end
                        end
                    end
                end
                MD_RUN: begin
                    r_p   <= w_p_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_state <= MD_FIX;
                    end
                end
                MD_FIX: begin
                    if (r_op == MD_OP_MULT) begin
                        r_hi <= r_p[2*WIDTH:WIDTH+1];
                        r_lo <= r_p[WIDTH:1];
                    end else begin
                        // Remainder takes the dividend's sign.
                        r_lo <= r_q_neg ? (~w_quot + WIDTH'(1)) : w_quot;
                        r_hi <= r_a_neg ? (~w_rem + WIDTH'(1)) : w_rem;
                    end
                    r_done  <= 1'b1;
                    r_state <= MD_DONE;
                end
                MD_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= MD_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= MD_IDLE;
                end
            endcase
        end
    end

    assign md.busy = r_busy;
    assign md.done = r_done;
    assign md.div0 = r_div0;
    assign md.hi   = r_hi;
    assign md.lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
//  Module   : tb_mult_div_unit
//  Brief    : Directed scoreboard bench for the iterative multiplier/divider
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mult_div_unit;
    import cpu_defs::*;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         div0;
    } exp_t;

    logic clk      = 1'b0;
    logic reset_in = 1'b1;
    int   checks   = 0;
    int   errors   = 0;

    exp_t         exp_q[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(W)) md_bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_in (reset_in),
        .md       (md_bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference results from 64-bit signed arithmetic (truncating division).
    task automatic push_exp(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa;
        longint sbv;
        longint p;
        longint q;
        longint r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        if (op == MD_OP_DIV && b == '0) begin
            e = '{m_hi, m_lo, 1'b1};
        end else if (op == MD_OP_MULT) begin
            p = sa * sbv;
            e = '{p[63:32], p[31:0], 1'b0};
        end else begin
            q = sa / sbv;
            r = sa % sbv;
            e = '{r[31:0], q[31:0], 1'b0};
        end
        m_hi = e.hi;
        m_lo = e.lo;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        md_bus.start = 1'b1;
        md_bus.op    = op;
        md_bus.a     = a;
        md_bus.b     = b;
        push_exp(op, a, b);
        @(posedge clk);
        #1;
        md_bus.start = 1'b0;
        md_bus.op    = ~op;
        md_bus.a     = $urandom;
        md_bus.b     = $urandom;
    endtask

    task automatic compare_result(input string tag);
        exp_t e;
        check({tag, " pending"}, 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, " hi"},   64'(md_bus.hi),   64'(e.hi));
            check({tag, " lo"},   64'(md_bus.lo),   64'(e.lo));
            check({tag, " div0"}, 64'(md_bus.div0), 64'(e.div0));
        end
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int n   = 0;
        bit got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            got = md_bus.done;
        end
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        if (got) begin
            check({tag, " busy"}, 64'(md_bus.busy), 64'(1));
            compare_result(tag);
            @(negedge clk);
            check({tag, " done_pulse"}, 64'(md_bus.done), 64'(0));
            check({tag, " busy_end"},   64'(md_bus.busy), 64'(0));
        end
    endtask

    initial begin
        int n;
        int dones;
        int lat;

        md_bus.start = 1'b0;
        md_bus.op    = MD_OP_MULT;
        md_bus.a     = '0;
        md_bus.b     = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(md_bus.busy), 64'(0));
        check("reset done", 64'(md_bus.done), 64'(0));
        check("reset div0", 64'(md_bus.div0), 64'(0));
        check("reset hi",   64'(md_bus.hi),   64'(0));
        check("reset lo",   64'(md_bus.lo),   64'(0));
        reset_in = 1'b0;

        issue(MD_OP_MULT, 32'd7, 32'hFFFF_FFFD);
        wait_done("mult_7x-3", 34);
        issue(MD_OP_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_done("mult_min_sq", 34);
        issue(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_-7/2", 34);
        issue(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_min/-1", 34);
        issue(MD_OP_DIV, 32'd100, 32'hFFFF_FFF9);
        wait_done("div_100/-7", 34);

        // Leaves hi=0x11, lo=0x22 ahead of the divide-by-zero.
        issue(MD_OP_DIV, 32'h451, 32'h20);
        wait_done("div_setup", 34);
        issue(MD_OP_DIV, 32'd5, 32'd0);
        wait_done("div_by_zero", 1);
        @(negedge clk);
        check("div0 held", 64'(md_bus.div0), 64'(1));
        issue(MD_OP_MULT, 32'd3, 32'd5);
        wait_done("mult_clears_div0", 34);

        // Starts at cycles 5 and 20 of RUN and during DONE must be ignored.
        issue(MD_OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
        n     = 0;
        dones = 0;
        lat   = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (md_bus.done) begin
                dones++;
                lat = n;
                compare_result("ignored_starts");
            end
            md_bus.start = (n == 5 || n == 20 || n == 34);
            md_bus.op    = n[0];
            md_bus.a     = $urandom;
            md_bus.b     = $urandom;
        end
        md_bus.start = 1'b0;
        check("ignored_starts done_count", 64'(dones), 64'(1));
        check("ignored_starts latency",    64'(lat),   64'(34));
        check("ignored_starts idle",       64'(md_bus.busy), 64'(0));

        // Reset in the middle of RUN discards the operation.
        issue(MD_OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        repeat (17) @(negedge clk);
        reset_in = 1'b1;
        @(negedge clk);
        reset_in = 1'b0;
        check("midreset busy", 64'(md_bus.busy), 64'(0));
        check("midreset hi",   64'(md_bus.hi),   64'(0));
        check("midreset lo",   64'(md_bus.lo),   64'(0));
        void'(exp_q.pop_back());
        m_hi  = '0;
        m_lo  = '0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (md_bus.done) dones++;
        end
        check("midreset no_done", 64'(dones), 64'(0));
        issue(MD_OP_MULT, 32'd3, 32'd4);
        wait_done("mult_after_reset", 34);

        check("scoreboard empty", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
